// File: rtl/tick_timer.sv
// Programmable countdown timer driven by an upstream one-cycle tick pulse.
// One-shot or periodic expiry, with pause, cancel, retrigger and a saturating expiry count.
module tick_timer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             cancel,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic [WIDTH-1:0] remaining,
  output logic [CNT_W-1:0] expiries
);

  localparam logic [1:0]       ST_IDLE   = 2'd0;
  localparam logic [1:0]       ST_RUN    = 2'd1;
  localparam logic [1:0]       ST_PAUSED = 2'd2;
  localparam logic [CNT_W-1:0] EXP_MAX   = {CNT_W{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] reload_q,    reload_d;
  logic             mode_q,      mode_d;
  logic             done_q,      done_d;
  logic [CNT_W-1:0] expiries_q,  expiries_d;
  logic             busy_q,      busy_d;
  logic             paused_q,    paused_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == EXP_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Next-state: cancel beats start, start beats pause/tick.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    reload_d    = reload_q;
    mode_d      = mode_q;
    expiries_d  = expiries_q;
    done_d      = 1'b0;
    if (cancel && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      remaining_d = CNT_ZERO;
    end else if (start) begin
      reload_d    = load_val;
      mode_d      = auto_reload;
      if (load_val != CNT_ZERO) begin
        state_d     = ST_RUN;
        remaining_d = load_val;
        expiries_d  = {CNT_W{1'b0}};
      end else begin
        state_d     = ST_IDLE;
        remaining_d = CNT_ZERO;
        expiries_d  = {{(CNT_W-1){1'b0}}, 1'b1};
        done_d      = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            if (remaining_q > CNT_ONE) begin
              remaining_d = remaining_q - CNT_ONE;
            end else begin
              done_d     = 1'b1;
              expiries_d = sat_inc(expiries_q);
              if (mode_q) begin
                remaining_d = reload_q;
              end else begin
                remaining_d = CNT_ZERO;
                state_d     = ST_IDLE;
              end
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSED: begin
          // Leaving pause swallows any tick in the same cycle.
          if (!pause) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSED;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          remaining_d = CNT_ZERO;
        end
      endcase
    end
    busy_d   = (state_d != ST_IDLE);
    paused_d = (state_d == ST_PAUSED);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= CNT_ZERO;
      reload_q    <= CNT_ZERO;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
      expiries_q  <= {CNT_W{1'b0}};
      busy_q      <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      reload_q    <= reload_d;
      mode_q      <= mode_d;
      done_q      <= done_d;
      expiries_q  <= expiries_d;
      busy_q      <= busy_d;
      paused_q    <= paused_d;
    end
  end

  assign busy      = busy_q;
  assign paused    = paused_q;
  assign done      = done_q;
  assign remaining = remaining_q;
  assign expiries  = expiries_q;

endmodule

// File: tb/tb_tick_timer.sv
// Scoreboard bench for tick_timer: a tick-counting reference model pushes expected
// outputs each edge, and a monitor pops and compares them after the edge.
module tb_tick_timer;
  localparam int WIDTH = 16;
  localparam int CNT_W = 2;
  localparam int EXP_SAT = (1 << CNT_W) - 1;

  logic             clk, reset, tick, start, auto_reload, pause, cancel;
  logic [WIDTH-1:0] load_val;
  logic             busy, paused, done;
  logic [WIDTH-1:0] remaining;
  logic [CNT_W-1:0] expiries;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic busy;
    logic paused;
    logic done;
    int   remaining;
    int   expiries;
  } exp_t;
  exp_t sb_q[$];

  tick_timer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .load_val(load_val),
    .auto_reload(auto_reload), .pause(pause), .cancel(cancel), .busy(busy),
    .paused(paused), .done(done), .remaining(remaining), .expiries(expiries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counts accepted ticks against a target instead of counting down.
  initial begin : model
    bit active = 0, held = 0, periodic = 0, fired = 0;
    int target = 0, seen = 0, fires = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      fired = 0;
      if (!reset) begin
        active = 0; held = 0; periodic = 0; target = 0; seen = 0; fires = 0;
      end else if (cancel && active) begin
        active = 0; held = 0; target = 0; seen = 0;
      end else if (start) begin
        held = 0; seen = 0;
        if (load_val != 0) begin
          active = 1; target = int'(load_val); periodic = auto_reload; fires = 0;
        end else begin
          active = 0; target = 0; fired = 1; fires = 1;
        end
      end else if (active && held) begin
        if (!pause) held = 0;
      end else if (active) begin
        if (pause) held = 1;
        else if (tick) begin
          seen++;
          if (seen == target) begin
            fired = 1;
            if (fires < EXP_SAT) fires++;
            seen = 0;
            if (!periodic) begin
              active = 0; target = 0;
            end
          end
        end
      end
      e.busy = active; e.paused = held; e.done = fired;
      e.remaining = target - seen; e.expiries = fires;
      sb_q.push_back(e);
    end
  end

  // Monitor: one expected record per edge, compared shortly after that edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        if (busy !== e.busy || paused !== e.paused || done !== e.done ||
            int'(remaining) != e.remaining || int'(expiries) != e.expiries || $isunknown(remaining)) begin
          errors++;
          $display("FAIL outputs at %0t: got busy=%0b paused=%0b done=%0b rem=%0d exp=%0d want busy=%0b paused=%0b done=%0b rem=%0d exp=%0d",
                   $time, busy, paused, done, remaining, expiries,
                   e.busy, e.paused, e.done, e.remaining, e.expiries);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step(input logic t, input logic s, input int lv, input logic ar,
                      input logic p, input logic c);
    tick = t; start = s; load_val = WIDTH'(lv); auto_reload = ar; pause = p; cancel = c;
    @(negedge clk);
  endtask

  initial begin : driver
    logic p_lvl;
    tick = 0; start = 0; load_val = '0; auto_reload = 0; pause = 0; cancel = 0;
    reset = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_rem", int'(remaining), 0);

    for (int i = 0; i < 10; i++) step(i[0], 0, 0, 0, 0, 0);
    chk("idle_ticks_busy", int'(busy), 0);
    chk("idle_ticks_rem", int'(remaining), 0);

    step(0, 1, 3, 0, 0, 0);
    chk("oneshot_load", int'(remaining), 3);
    for (int i = 0; i < 12; i++) step((i % 4) == 3, 0, 0, 0, 0, 0);
    chk("oneshot_busy", int'(busy), 0);
    chk("oneshot_exp", int'(expiries), 1);

    step(0, 1, 2, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0);
    chk("periodic_sat", int'(expiries), 3);
    chk("periodic_busy", int'(busy), 1);
    step(0, 0, 0, 0, 0, 1);
    chk("cancel_hold_exp", int'(expiries), 3);

    step(0, 1, 5, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 0);
    chk("pause_paused", int'(paused), 1);
    chk("pause_rem", int'(remaining), 3);
    step(1, 0, 0, 0, 0, 0);
    chk("resume_tick_ignored", int'(remaining), 3);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("resume_no_early_done", int'(done), 0);
    step(1, 0, 0, 0, 0, 0);
    chk("resume_done", int'(done), 1);

    step(0, 1, 2, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    chk("cancel_tick_done", int'(done), 0);
    chk("cancel_tick_busy", int'(busy), 0);
    step(0, 1, 3, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 7, 0, 0, 0);
    chk("retrigger_rem", int'(remaining), 7);
    chk("retrigger_done", int'(done), 0);
    step(0, 0, 0, 0, 0, 1);

    step(0, 1, 0, 0, 0, 0);
    chk("zero_len_done", int'(done), 1);
    chk("zero_len_busy", int'(busy), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("zero_len_pulse", int'(done), 0);

    step(0, 1, 6, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("pre_reset_rem", int'(remaining), 4);
    #2 reset = 0;
    #1;
    chk("async_rst_rem", int'(remaining), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    @(negedge clk);
    reset = 1;

    p_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) p_lvl = ~p_lvl;
      step(($urandom_range(0, 1) == 1) || (i % 500 < 60), $urandom_range(0, 19) == 0,
           $urandom_range(0, 5), $urandom_range(0, 1) == 1, p_lvl,
           $urandom_range(0, 39) == 0);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tick_timer.md
Name: tick_timer

Overview:
Programmable countdown timer that consumes the one-cycle tick pulse from the clock-gate/tick generator stage. Each accepted tick decrements a loaded count. On expiry the block emits a one-cycle done pulse, and either returns to idle or reloads for periodic operation. It sits between the tick generator and control logic that needs timeouts or periodic events (LED blink, display scan, polling intervals).

Parameters:
WIDTH, 16, width of load value and remaining-count registers
CNT_W, 8, width of the saturating expiry counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
tick  in  1  one-cycle enable pulse from the upstream tick generator
start  in  1  single-cycle request: load load_val and begin counting
load_val  in  WIDTH  tick count to load, sampled only when start=1
auto_reload  in  1  sampled with start; 1 = periodic mode
pause  in  1  level; while high, ticks are ignored
cancel  in  1  single-cycle abort request
busy  out  1  high in RUN or PAUSED
paused  out  1  high in PAUSED
done  out  1  one-cycle pulse on expiry
remaining  out  WIDTH  current remaining tick count
expiries  out  CNT_W  saturating count of done pulses since the last start

Behaviour:
- All outputs are registered. reset=0 asynchronously forces the following:
  - state=IDLE
  - remaining=0, reload_reg=0, mode_reg=0
  - busy=0, paused=0, done=0, expiries=0
- States: IDLE, RUN, PAUSED. busy=(state!=IDLE). paused=(state==PAUSED).
- done defaults to 0 every cycle. It is high for exactly one cycle, in the cycle after the expiring edge.
- Priority per edge: reset > cancel > start > pause/tick.
- IDLE:
  - start=1, load_val!=0: latch reload_reg=load_val and mode_reg=auto_reload; remaining=load_val; expiries=0; go to RUN. A tick in the same cycle is ignored.
  - start=1, load_val==0: zero-length timer. done=1 next cycle, expiries=1, stay IDLE, remaining=0.
  - tick, pause and cancel have no effect.
- RUN:
  - pause=1: go to PAUSED. A tick in the same cycle is ignored.
  - tick=1, pause=0, remaining>1: remaining decrements by 1.
  - tick=1, pause=0, remaining==1 (expiry): done=1; expiries increments, saturating at 2^CNT_W-1.
    - mode_reg=1: remaining=reload_reg, stay RUN.
    - mode_reg=0: remaining=0, go to IDLE.
- PAUSED:
  - remaining is held and ticks are ignored.
  - pause=0: return to RUN. A tick in that same cycle is ignored; counting resumes on the next tick.
- start while RUN or PAUSED (retrigger): reload from load_val/auto_reload, clear expiries, enter RUN (even from PAUSED), no done. A concurrent tick is ignored. load_val==0 on retrigger behaves as in IDLE: done pulse, go to IDLE.
- cancel in RUN or PAUSED: go to IDLE, remaining=0, no done. expiries is held. cancel in IDLE is a no-op.
- Latency: from the edge sampling start, the first decrement needs a tick ≥1 cycle later. done rises on the edge that samples the N-th accepted tick.
- tick held high continuously is legal: one decrement per cycle.
- Reset asserted mid-count aborts immediately with no done pulse. Deassertion is expected synchronous to clk (synchronized upstream).

Test Plan:
1. Reset then idle: reset=0 for 3 cycles, then 1 → all outputs 0. Toggling tick 10 times leaves remaining=0, busy=0.
2. One-shot: start with load_val=3, auto_reload=0, ticks every 4th cycle → remaining 3,2,1. done is a single 1-cycle pulse after the 3rd tick, then busy=0, remaining=0, expiries=1.
3. Periodic and saturation (CNT_W=2 build): start load_val=2, auto_reload=1, tick held high → done every 2nd cycle, remaining alternates 2,1. expiries goes 1,2,3 then stays 3 after the 4th done.
4. Pause/resume: load_val=5, two ticks (remaining=3), pause=1 with 4 ticks → remaining stays 3, paused=1. pause=0 → expires after exactly 3 further ticks, no early done.
5. Simultaneous events: in RUN with remaining=1, assert cancel and tick in the same cycle → IDLE, no done. Repeat with start(load_val=7) and tick together → remaining=7, no done.
6. Edge cases:
   - start with load_val=0 → done one cycle later, busy never rises.
   - reset asserted mid-count at remaining=4 → outputs cleared asynchronously (before the next clk edge), no done.
